pwm_multi_driver: RTL and testbench
===================================

# pwm_multi_driver

Parametrised multi-channel PWM generator for servo and LED drive. A shared period counter advances on a prescaled tick derived from `gen_clk`. Per-channel duty values are written through a valid/ready port into pending registers and committed to shadow registers only at a period boundary, so every output pulse is glitch-free. The block supports edge-aligned and center-aligned modes and per-channel output inversion, and it replaces single-channel drivers at the top level.

## Interface

**Parameters**
- `CHANNELS`, 4: number of PWM outputs (≥1).
- `WIDTH`, 13: duty and counter width.
- `PERIOD`, 2000: counter ticks per edge-aligned period. Range 2 ≤ PERIOD ≤ 2^WIDTH−1.
- `DIV`, 1000: `gen_clk` cycles per counter tick (≥1).
- `INVERT`, 0: CHANNELS-bit mask. Bit i=1 inverts `o_signal[i]`.
- `DUTY_INIT`, 0: reset value of every pending and shadow duty.

**Ports**
- `gen_clk`, in, 1: block clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_en`, in, 1: run enable.
- `i_mode`, in, 1: 0 = edge-aligned, 1 = center-aligned. Sampled at period boundary.
- `i_wr_valid`, in, 1: duty write request.
- `o_wr_ready`, out, 1: write can be accepted.
- `i_wr_ch`, in, max(1,$clog2(CHANNELS)): target channel.
- `i_wr_duty`, in, WIDTH: new duty in ticks.
- `o_signal`, out, CHANNELS: PWM outputs (registered).
- `o_period_start`, out, 1: one-cycle pulse at each period boundary (registered).

## Operation

**Prescaler**
- `pre` counts 0..DIV−1 while `i_en`=1.
- A tick occurs in the cycle where pre==DIV−1; pre then wraps to 0.

**Counter `cnt`, advancing on ticks only**
- Edge mode: 0,1,…,PERIOD−1,0,…
- Center mode: up phase 0..PERIOD−1, then down phase PERIOD−1..0, then up again. Full cycle is 2·PERIOD ticks; each endpoint appears twice in a row.
- Boundary tick: the tick that moves `cnt` into the first value of a new period. In edge mode this is PERIOD−1→0. In center mode it is the down-phase 0 → up-phase 0 transition.

**Commit at boundary tick, same edge**
- All shadow duties ← pending duties.
- Active mode ← `i_mode`.
- `o_period_start` ← 1 for one cycle.

**Write port**
- Accepted when `i_wr_valid` && `o_wr_ready`: pending[`i_wr_ch`] ← `i_wr_duty`.
- `i_wr_ch` ≥ CHANNELS: write is accepted and discarded.
- `o_wr_ready` is combinational. It is 0 during reset and in the boundary-tick cycle; otherwise 1. A write and a commit therefore never coincide.
- A write accepted in the cycle before a boundary tick is included in that commit.

**Compare (raw level per channel)**
- Edge mode: high when `cnt` < shadow duty.
- Center mode: high when `cnt` ≥ PERIOD − shadow duty.
- Results:
  - Duty=0 gives constant low.
  - Duty ≥ PERIOD gives constant high.
  - Edge mode: high for exactly `duty` ticks per period.
  - Center mode: high for 2·`duty` ticks, centered on the top of the count.
- `o_signal[i]` ← raw XOR `INVERT[i]`.

**`i_en`=0**
- `pre`, `cnt` and phase are held at 0/up.
- Shadows ← pending every cycle; active mode ← `i_mode`.
- `o_signal` = INVERT; `o_period_start` = 0.
- Writes are still accepted.
- On re-enable the period starts cleanly from `cnt`=0.

## Timing

**Reset values**
- `pre`=0, `cnt`=0, phase up, active mode edge.
- Pending and shadow duties = DUTY_INIT.
- `o_signal`=INVERT, `o_period_start`=0, `o_wr_ready`=0.

**Reset mid-period:** all state returns immediately (asynchronously) to the values above. Pending writes are lost.

**Latency**
- `o_signal` is registered from the current `cnt` and shadow duty, so it lags the counter by 1 `gen_clk` cycle.
- `o_period_start` is asserted the cycle after the boundary tick edge, aligned with the first output sample of the new period.

**Write-to-output latency:** the new duty appears from the first sample of the next period, i.e. up to one full period plus 1 cycle.

**Width rule:** comparisons are unsigned at WIDTH bits. PERIOD − duty saturates at 0 when duty > PERIOD.

## Test plan

Test configuration: CHANNELS=4, PERIOD=10, DIV=1, INVERT=0, DUTY_INIT=0 unless stated.

1. **Reset and default levels.** Release reset with `i_en`=1 → `o_signal`=0000 constantly, `o_period_start` pulses every 10 cycles, `o_wr_ready`=0 exactly on boundary-tick cycles.
2. **Edge duties.** Write duties 0/3/10/15 to ch0–3 mid-period → unchanged until next boundary, then per 10-cycle period: ch0 low always, ch1 high 3 cycles from period start, ch2 and ch3 high always.
3. **Boundary write.** Write duty 5 to ch1 in the cycle before the boundary tick → accepted, visible in the very next period. A write held valid during the boundary cycle waits (ready=0) and commits one period later.
4. **Center mode.** Set `i_mode`=1 with ch0 duty 2 → after boundary, period=20 cycles, ch0 high 4 cycles centered on `cnt`=9 (two 9s), `o_period_start` every 20 cycles.
5. **Prescaler and inversion.** DIV=3, INVERT=0001, ch0 duty 4 → `cnt` advances every 3 cycles, `o_signal[0]` low 12 cycles and high 18 cycles per 30-cycle period.
6. **Disable and reset mid-run.** Drop `i_en` at `cnt`=6 → outputs = INVERT next cycle. Re-enable → `cnt` restarts at 0 with all pending duties applied. Assert `i_rst_n`=0 mid-period → outputs = INVERT, and duties return to DUTY_INIT after release.

Source files
------------

// File: rtl/pwm_multi_driver.sv
// Multi-channel PWM generator: shared prescaled period counter, edge/center alignment,
// per-channel inversion, and duty updates committed only at period boundaries.
module pwm_multi_driver #(
  parameter int unsigned         CHANNELS  = 4,
  parameter int unsigned         WIDTH     = 13,
  parameter int unsigned         PERIOD    = 2000,
  parameter int unsigned         DIV       = 1000,
  parameter logic [CHANNELS-1:0] INVERT    = {CHANNELS{1'b0}},
  parameter logic [WIDTH-1:0]    DUTY_INIT = {WIDTH{1'b0}},
  localparam int unsigned        CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                gen_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_mode,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [WIDTH-1:0]    i_wr_duty,
  output logic [CHANNELS-1:0] o_signal,
  output logic                o_period_start
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] PER_W    = WIDTH'(PERIOD);

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  typedef enum logic {PH_UP = 1'b0, PH_DOWN = 1'b1} phase_e;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  phase_e              phase_q, phase_d;
  mode_e               mode_q, mode_d;
  logic [WIDTH-1:0]    pend_q [CHANNELS];
  logic [WIDTH-1:0]    pend_d [CHANNELS];
  logic [WIDTH-1:0]    shad_q [CHANNELS];
  logic [WIDTH-1:0]    shad_d [CHANNELS];
  logic [WIDTH-1:0]    thr_s  [CHANNELS];
  logic [CHANNELS-1:0] raw_s;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic                ps_q, ps_d;
  logic                tick_s, at_end_s, boundary_s, ready_s, wr_fire_s;

  // Tick and period-boundary detection
  always_comb begin
    tick_s = i_en && (pre_q == PRE_LAST);
    if (mode_q == MODE_CENTER) begin
      at_end_s = (phase_q == PH_DOWN) && (cnt_q == CNT_ZERO);
    end else begin
      at_end_s = (cnt_q == CNT_LAST);
    end
    boundary_s = tick_s && at_end_s;
    // Ready drops on the commit cycle so a write never races the shadow update.
    ready_s    = i_rst_n && !boundary_s;
    wr_fire_s  = i_wr_valid && ready_s;
  end

  assign o_wr_ready = ready_s;

  // Prescaler, period counter, phase and active-mode next state
  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    if (!i_en) begin
      pre_d   = PRE_ZERO;
      cnt_d   = CNT_ZERO;
      phase_d = PH_UP;
      mode_d  = mode_e'(i_mode);
    end else if (tick_s) begin
      pre_d = PRE_ZERO;
      if (boundary_s) begin
        cnt_d   = CNT_ZERO;
        phase_d = PH_UP;
        mode_d  = mode_e'(i_mode);
      end else if (mode_q == MODE_CENTER) begin
        // The top value is held for one extra tick while the phase turns around.
        if (phase_q == PH_UP) begin
          if (cnt_q == CNT_LAST) begin
            phase_d = PH_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  // Pending duty writes and shadow commit
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_fire_s && (i_wr_ch == CH_W'(i))) begin
        pend_d[i] = i_wr_duty;
      end else begin
        pend_d[i] = pend_q[i];
      end
      if (!i_en || boundary_s) begin
        shad_d[i] = pend_q[i];
      end else begin
        shad_d[i] = shad_q[i];
      end
    end
  end

  // Per-channel compare and output polarity
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (shad_q[i] >= PER_W) begin
        thr_s[i] = CNT_ZERO;
      end else begin
        thr_s[i] = PER_W - shad_q[i];
      end
      if (mode_q == MODE_CENTER) begin
        raw_s[i] = (cnt_q >= thr_s[i]);
      end else begin
        raw_s[i] = (cnt_q < shad_q[i]);
      end
    end
    if (i_en) begin
      sig_d = raw_s ^ INVERT;
    end else begin
      sig_d = INVERT;
    end
    ps_d = boundary_s;
  end

  // State and output registers
  always_ff @(posedge gen_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q   <= PRE_ZERO;
      cnt_q   <= CNT_ZERO;
      phase_q <= PH_UP;
      mode_q  <= MODE_EDGE;
      sig_q   <= INVERT;
      ps_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= DUTY_INIT;
        shad_q[i] <= DUTY_INIT;
      end
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      sig_q   <= sig_d;
      ps_q    <= ps_d;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= pend_d[i];
        shad_q[i] <= shad_d[i];
      end
    end
  end

  assign o_signal       = sig_q;
  assign o_period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_driver.sv
// Scoreboard bench for pwm_multi_driver: two instances (DIV=1/INVERT=0 and DIV=3/INVERT=0001)
// share stimulus; a period-position model predicts every registered output and ready.
module tb_pwm_multi_driver;

  localparam int P = 10;

  logic        gen_clk = 1'b0;
  logic        rst_n, en, mode, wr_valid;
  logic [1:0]  wr_ch;
  logic [12:0] wr_duty;
  logic        ready_a, ready_b, ps_a, ps_b;
  logic [3:0]  sig_a, sig_b;

  logic        s_rst_n, s_en, s_mode, s_wr_valid;
  logic [1:0]  s_wr_ch;
  logic [12:0] s_wr_duty;

  int          m_pre [2];
  int          m_pos [2];
  bit          m_mode [2];
  int          m_pend [2][4];
  int          m_shad [2][4];
  logic [4:0]  exp_a [$];
  logic [4:0]  exp_b [$];

  int checks = 0;
  int failures = 0;
  int hi_a [4];
  int hi_b [4];
  int ps_cnt_a, ps_cnt_b, nready_a;
  bit obs_ps_a, obs_ps_b;

  pwm_multi_driver #(.CHANNELS(4), .WIDTH(13), .PERIOD(P), .DIV(1),
                     .INVERT(4'b0000), .DUTY_INIT(13'd0)) dut_a (
    .gen_clk(gen_clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
    .i_wr_valid(wr_valid), .o_wr_ready(ready_a), .i_wr_ch(wr_ch),
    .i_wr_duty(wr_duty), .o_signal(sig_a), .o_period_start(ps_a));

  pwm_multi_driver #(.CHANNELS(4), .WIDTH(13), .PERIOD(P), .DIV(3),
                     .INVERT(4'b0001), .DUTY_INIT(13'd0)) dut_b (
    .gen_clk(gen_clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
    .i_wr_valid(wr_valid), .o_wr_ready(ready_b), .i_wr_ch(wr_ch),
    .i_wr_duty(wr_duty), .o_signal(sig_b), .o_period_start(ps_b));

  always #5 gen_clk = ~gen_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Reference: position pos runs 0..PERIOD-1 (edge) or 0..2*PERIOD-1 (center).
  task automatic model_step(input int k, output bit rdy);
    int dv, last, cnt, d;
    bit tick, bnd;
    logic [3:0] raw, inv;
    logic [4:0] e;
    dv  = (k == 0) ? 1 : 3;
    inv = (k == 0) ? 4'b0000 : 4'b0001;
    if (!rst_n) begin
      m_pre[k] = 0; m_pos[k] = 0; m_mode[k] = 1'b0;
      for (int c = 0; c < 4; c++) begin m_pend[k][c] = 0; m_shad[k][c] = 0; end
      rdy = 1'b0;
      e = {inv, 1'b0};
    end else begin
      last = m_mode[k] ? 2 * P - 1 : P - 1;
      tick = en && (m_pre[k] == dv - 1);
      bnd  = tick && (m_pos[k] == last);
      rdy  = !bnd;
      cnt  = (m_pos[k] >= P) ? (2 * P - 1 - m_pos[k]) : m_pos[k];
      for (int c = 0; c < 4; c++) begin
        d = m_shad[k][c];
        raw[c] = m_mode[k] ? (cnt + d >= P) : (cnt < d);
      end
      if (!en) begin
        e = {inv, 1'b0};
        m_pre[k] = 0; m_pos[k] = 0; m_mode[k] = mode;
        for (int c = 0; c < 4; c++) m_shad[k][c] = m_pend[k][c];
      end else begin
        e = {raw ^ inv, bnd};
        if (tick) begin
          m_pre[k] = 0;
          if (bnd) begin
            m_pos[k] = 0; m_mode[k] = mode;
            for (int c = 0; c < 4; c++) m_shad[k][c] = m_pend[k][c];
          end else begin
            m_pos[k]++;
          end
        end else begin
          m_pre[k]++;
        end
      end
      if (wr_valid && rdy) m_pend[k][wr_ch] = int'(wr_duty);
    end
    if (k == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  function automatic bit pred_ready(input int k);
    int dv, last;
    dv   = (k == 0) ? 1 : 3;
    last = m_mode[k] ? 2 * P - 1 : P - 1;
    return !(s_en && (m_pre[k] == dv - 1) && (m_pos[k] == last));
  endfunction

  task automatic cycle();
    logic [4:0] e;
    bit ra, rb;
    @(negedge gen_clk);
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check_eq("sig_a", int'(sig_a), int'(e[4:1]));
      check_eq("ps_a", int'(ps_a), int'(e[0]));
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check_eq("sig_b", int'(sig_b), int'(e[4:1]));
      check_eq("ps_b", int'(ps_b), int'(e[0]));
    end
    obs_ps_a = ps_a;
    obs_ps_b = ps_b;
    for (int c = 0; c < 4; c++) begin
      hi_a[c] += int'(sig_a[c]);
      hi_b[c] += int'(sig_b[c]);
    end
    ps_cnt_a += int'(ps_a);
    ps_cnt_b += int'(ps_b);
    rst_n = s_rst_n; en = s_en; mode = s_mode;
    wr_valid = s_wr_valid; wr_ch = s_wr_ch; wr_duty = s_wr_duty;
    #1;
    model_step(0, ra);
    model_step(1, rb);
    check_eq("ready_a", int'(ready_a), int'(ra));
    check_eq("ready_b", int'(ready_b), int'(rb));
    nready_a += int'(!ready_a);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_acc();
    for (int c = 0; c < 4; c++) begin hi_a[c] = 0; hi_b[c] = 0; end
    ps_cnt_a = 0; ps_cnt_b = 0; nready_a = 0;
  endtask

  task automatic wait_pos_a(input int target);
    int n = 0;
    while (m_pos[0] != target && n < 100) begin cycle(); n++; end
    check_eq("wait_pos_a", m_pos[0], target);
  endtask

  task automatic wait_ps(input int k);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      cycle(); n++;
      seen = (k == 0) ? obs_ps_a : obs_ps_b;
    end
    check_eq((k == 0) ? "wait_ps_a" : "wait_ps_b", int'(seen), 1);
  endtask

  task automatic write_both(input int ch, input int duty);
    int n = 0;
    while (!(pred_ready(0) && pred_ready(1)) && n < 10) begin cycle(); n++; end
    s_wr_valid = 1'b1; s_wr_ch = 2'(ch); s_wr_duty = 13'(duty);
    cycle();
    s_wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; wr_valid = 1'b0; wr_ch = 2'd0; wr_duty = 13'd0;
    s_rst_n = 1'b0; s_en = 1'b0; s_mode = 1'b0; s_wr_valid = 1'b0; s_wr_ch = 2'd0; s_wr_duty = 13'd0;
    clear_acc();
    run(3);

    // Reset release, default levels
    s_rst_n = 1'b1; s_en = 1'b1;
    run(3);
    clear_acc();
    run(30);
    check_eq("t1_ps_a", ps_cnt_a, 3);
    check_eq("t1_nready_a", nready_a, 3);
    check_eq("t1_hi_a3", hi_a[3], 0);
    check_eq("t1_ps_b", ps_cnt_b, 1);
    check_eq("t1_hi_b0", hi_b[0], 30);

    // Edge duties written mid-period
    wait_pos_a(4);
    write_both(0, 0); write_both(1, 3); write_both(2, 10); write_both(3, 15);
    wait_ps(0);
    clear_acc();
    run(10);
    check_eq("t2_hi_a0", hi_a[0], 0);
    check_eq("t2_hi_a1", hi_a[1], 3);
    check_eq("t2_hi_a2", hi_a[2], 10);
    check_eq("t2_hi_a3", hi_a[3], 10);
    check_eq("t2_ps_a", ps_cnt_a, 1);

    // Write in the cycle before the boundary tick
    wait_pos_a(P - 2);
    s_wr_valid = 1'b1; s_wr_ch = 2'd1; s_wr_duty = 13'd5;
    cycle();
    s_wr_valid = 1'b0;
    wait_ps(0);
    clear_acc();
    run(10);
    check_eq("t3_hi_a1", hi_a[1], 5);
    // Write held across the boundary cycle waits one period
    wait_pos_a(P - 1);
    s_wr_valid = 1'b1; s_wr_ch = 2'd1; s_wr_duty = 13'd7;
    cycle();
    check_eq("t3_hold_ready", int'(ready_a), 0);
    cycle();
    s_wr_valid = 1'b0;
    wait_ps(0);
    clear_acc();
    run(10);
    check_eq("t3_hi_a1_late", hi_a[1], 7);

    // Center-aligned mode
    write_both(0, 2);
    s_mode = 1'b1;
    wait_ps(0);
    clear_acc();
    run(40);
    check_eq("t4_hi_a0", hi_a[0], 8);
    check_eq("t4_hi_a1", hi_a[1], 28);
    check_eq("t4_hi_a2", hi_a[2], 40);
    check_eq("t4_ps_a", ps_cnt_a, 2);

    // Prescaler and inversion on the DIV=3 instance
    s_mode = 1'b0;
    write_both(0, 4);
    wait_ps(1);
    clear_acc();
    run(30);
    check_eq("t5_hi_b0", hi_b[0], 18);
    check_eq("t5_hi_b1", hi_b[1], 21);
    check_eq("t5_hi_b2", hi_b[2], 30);
    check_eq("t5_ps_b", ps_cnt_b, 1);

    // Disable mid-period, write while disabled, re-enable
    wait_pos_a(6);
    s_en = 1'b0;
    cycle();
    cycle();
    check_eq("t6_dis_sig_a", int'(sig_a), 0);
    check_eq("t6_dis_sig_b", int'(sig_b), 1);
    write_both(2, 1);
    run(3);
    s_en = 1'b1;
    cycle();
    clear_acc();
    run(10);
    check_eq("t6_hi_a0", hi_a[0], 4);
    check_eq("t6_hi_a2", hi_a[2], 1);
    check_eq("t6_hi_a3", hi_a[3], 10);
    check_eq("t6_ps_a", ps_cnt_a, 1);

    // Asynchronous reset mid-period
    run(4);
    s_rst_n = 1'b0;
    cycle();
    check_eq("t6_rst_sig_a", int'(sig_a), 0);
    check_eq("t6_rst_sig_b", int'(sig_b), 1);
    check_eq("t6_rst_ps_a", int'(ps_a), 0);
    run(3);
    s_rst_n = 1'b1;
    run(2);
    clear_acc();
    run(30);
    check_eq("t6_post_hi_a2", hi_a[2], 0);
    check_eq("t6_post_hi_a3", hi_a[3], 0);
    check_eq("t6_post_hi_b0", hi_b[0], 30);
    check_eq("t6_post_ps_a", ps_cnt_a, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
